// File: rtl/mem_loader.sv
// Boot-time image loader: streams words into up to NUM_TARGETS BRAMs and stalls the core until done.
// Optional MEM_LOADER_CHECKSUM_EN adds a running checksum and an end-of-image checksum compare.
module mem_loader #(
    parameter  int DATA_WIDTH  = 32,
    parameter  int ADDR_WIDTH  = 12,
    parameter  int NUM_TARGETS = 2,
    parameter  int DEPTH_WORDS = 1024,
    localparam int SEL_W       = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1,
    localparam int CNT_W       = $clog2(DEPTH_WORDS) + 1,
    localparam int BE_W        = DATA_WIDTH / 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DATA_WIDTH-1:0]        s_data,
    input  logic [SEL_W-1:0]             s_sel,
    input  logic                         s_last,
    output logic [ADDR_WIDTH-1:0]        w_addr,
    output logic [DATA_WIDTH-1:0]        w_dat,
    output logic [NUM_TARGETS-1:0]       w_enb,
    output logic [BE_W-1:0]              w_byte_enb,
    output logic [NUM_TARGETS*CNT_W-1:0] word_count,
    output logic                         cpu_stall,
    output logic                         load_done,
`ifdef MEM_LOADER_CHECKSUM_EN
    input  logic [DATA_WIDTH-1:0]        expected_sum,
    output logic [DATA_WIDTH-1:0]        checksum,
`endif
    output logic                         load_err
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] count [NUM_TARGETS];
    logic [CNT_W-1:0] count_sel;
    logic             sel_ok, room_ok, accept, legal, sum_ok, clear;

    // Counter of the addressed target; out-of-range selects read as 0 and are rejected by sel_ok.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        count_sel = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (s_sel == SEL_W'(i)) count_sel = count[i];
        end
    end

    assign sel_ok  = (32'(s_sel) < NUM_TARGETS);
    assign room_ok = (count_sel < CNT_W'(DEPTH_WORDS));
    assign accept  = s_valid & s_ready;
    assign legal   = accept & sel_ok & room_ok;

`ifdef MEM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;
    assign checksum = sum_q;
    assign sum_ok   = ((sum_q + s_data) == expected_sum);
`else
    assign sum_ok   = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        clear      = 1'b0;
        case (state)
            LOAD: begin
                s_ready = 1'b1;
                if (accept) begin
                    if (!legal)      state_next = ERROR;
                    else if (s_last) state_next = sum_ok ? DONE : ERROR;
                end
            end
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_next = LOAD;
                    clear      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign load_done = (state == DONE);
    assign cpu_stall = (state != DONE);
    assign load_err  = (state == ERROR);

    // Write port is registered: one write per legal beat, zeroed in every other cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_enb      <= '0;
            w_addr     <= '0;
            w_dat      <= '0;
            w_byte_enb <= '0;
            // NOTE: the counter array is tiny register state, so it is reset explicitly.
            for (int i = 0; i < NUM_TARGETS; i++) count[i] <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep all sequential updates on the same edge.
            w_enb      <= '0;
            w_addr     <= '0;
            w_dat      <= '0;
            w_byte_enb <= '0;
            if (clear) begin
                for (int i = 0; i < NUM_TARGETS; i++) count[i] <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
                sum_q <= '0;
`endif
            end else if (legal) begin
                w_enb      <= NUM_TARGETS'(1) << s_sel;
                w_addr     <= ADDR_WIDTH'(count_sel) * ADDR_WIDTH'(BE_W);
                w_dat      <= s_data;
                w_byte_enb <= '1;
                for (int i = 0; i < NUM_TARGETS; i++) begin
                    if (s_sel == SEL_W'(i)) count[i] <= count[i] + CNT_W'(1);
                end
`ifdef MEM_LOADER_CHECKSUM_EN
                sum_q <= sum_q + s_data;
`endif
            end
        end
    end

    always_comb begin
        word_count = '0;
        for (int i = 0; i < NUM_TARGETS; i++) word_count[i*CNT_W +: CNT_W] = count[i];
    end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: two configurations (2x1024 and 3x4) driven from shared inputs,
// compared cycle by cycle against a transaction-level model of the load session.
module tb_mem_loader;

    localparam int DW = 32;
    localparam int AW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, s_valid, s_last;
    logic [DW-1:0] s_data;
    logic [1:0]    s_sel;

    logic          a_ready, a_stall, a_done, a_err;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_dat;
    logic [1:0]    a_enb;
    logic [3:0]    a_be;
    logic [21:0]   a_wc;

    logic          b_ready, b_stall, b_done, b_err;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_dat;
    logic [2:0]    b_enb;
    logic [3:0]    b_be;
    logic [8:0]    b_wc;

`ifdef MEM_LOADER_CHECKSUM_EN
    logic [DW-1:0] expected_sum, a_sum, b_sum;
    int            sum_bias = 0;
`endif

    mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_TARGETS(2), .DEPTH_WORDS(1024)) u_a (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(a_ready),
        .s_data(s_data), .s_sel(s_sel[0]), .s_last(s_last), .w_addr(a_addr), .w_dat(a_dat),
        .w_enb(a_enb), .w_byte_enb(a_be), .word_count(a_wc), .cpu_stall(a_stall),
        .load_done(a_done),
`ifdef MEM_LOADER_CHECKSUM_EN
        .expected_sum(expected_sum), .checksum(a_sum),
`endif
        .load_err(a_err)
    );

    mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_TARGETS(3), .DEPTH_WORDS(4)) u_b (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(b_ready),
        .s_data(s_data), .s_sel(s_sel), .s_last(s_last), .w_addr(b_addr), .w_dat(b_dat),
        .w_enb(b_enb), .w_byte_enb(b_be), .word_count(b_wc), .cpu_stall(b_stall),
        .load_done(b_done),
`ifdef MEM_LOADER_CHECKSUM_EN
        .expected_sum(expected_sum), .checksum(b_sum),
`endif
        .load_err(b_err)
    );

    // Outputs of the instance currently under test.
    bit            which;
    logic          o_ready, o_stall, o_done, o_err;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_dat;
    logic [2:0]    o_enb;
    logic [3:0]    o_be;
    assign o_ready = which ? b_ready : a_ready;
    assign o_stall = which ? b_stall : a_stall;
    assign o_done  = which ? b_done  : a_done;
    assign o_err   = which ? b_err   : a_err;
    assign o_addr  = which ? b_addr  : a_addr;
    assign o_dat   = which ? b_dat   : a_dat;
    assign o_enb   = which ? b_enb   : {1'b0, a_enb};
    assign o_be    = which ? b_be    : a_be;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [DW-1:0] o_sum;
    assign o_sum = which ? b_sum : a_sum;
`endif

    function automatic int obs_count(input int i);
        return which ? int'(b_wc[i*3 +: 3]) : int'(a_wc[i*11 +: 11]);
    endfunction

    // Session-level reference model.
    typedef enum {M_IDLE, M_LOAD, M_DONE, M_ERR} mstate_t;
    mstate_t       m_state;
    int            m_count [4];
    int            m_targets, m_depth;
    logic [DW-1:0] m_sum;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic select(input bit w, input int t, input int d);
        which     = w;
        m_targets = t;
        m_depth   = d;
    endtask

    task automatic check_counts();
        for (int i = 0; i < m_targets; i++) check($sformatf("word_count[%0d]", i), obs_count(i), m_count[i]);
    endtask

    // One clock cycle: drive inputs, advance the model across the edge, compare all outputs.
    task automatic step(input bit r, input bit st, input bit v, input logic [1:0] sel,
                        input logic [DW-1:0] d, input bit last);
        logic [2:0]    e_enb;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_dat;
        logic [3:0]    e_be;
        bit            sum_good;
        int            si;
        rst = r; start = st; s_valid = v; s_sel = sel; s_data = d; s_last = last;
`ifdef MEM_LOADER_CHECKSUM_EN
        expected_sum = m_sum + d + DW'(sum_bias);
`endif
        @(posedge clk);
        e_enb = '0; e_addr = '0; e_dat = '0; e_be = '0;
        si = int'(sel);
        if (r) begin
            m_state = M_IDLE;
            m_sum   = '0;
            for (int i = 0; i < 4; i++) m_count[i] = 0;
        end else if (m_state == M_LOAD) begin
            if (v) begin
                if (si < m_targets && m_count[si] < m_depth) begin
                    e_enb  = 3'(1) << si;
                    e_addr = AW'(m_count[si] * 4);
                    e_dat  = d;
                    e_be   = 4'hF;
                    m_count[si]++;
                    m_sum += d;
                    sum_good = 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
                    sum_good = (m_sum == expected_sum);
`endif
                    if (last) m_state = sum_good ? M_DONE : M_ERR;
                end else begin
                    m_state = M_ERR;
                end
            end
        end else if (st) begin
            m_state = M_LOAD;
            m_sum   = '0;
            for (int i = 0; i < 4; i++) m_count[i] = 0;
        end
        #1;
        check("w_enb", o_enb, e_enb);
        check("w_addr", o_addr, e_addr);
        check("w_dat", o_dat, e_dat);
        check("w_byte_enb", o_be, e_be);
        check("s_ready", o_ready, m_state == M_LOAD);
        check("load_done", o_done, m_state == M_DONE);
        check("cpu_stall", o_stall, m_state != M_DONE);
        check("load_err", o_err, m_state == M_ERR);
`ifdef MEM_LOADER_CHECKSUM_EN
        check("checksum", o_sum, m_sum);
`endif
    endtask

    logic [DW-1:0] img_dat [18];
    logic [1:0]    img_sel [18];

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_sel = '0;
        for (int i = 0; i < 18; i++) begin
            img_dat[i] = $urandom;
            img_sel[i] = (i < 4) ? 2'd1 : 2'd0;
        end

        // Reset state, then the 18-beat image with no gaps.
        select(0, 2, 1024);
        step(1, 0, 0, 0, 0, 0);
        check_counts();
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++) step(0, 0, 1, img_sel[i], img_dat[i], i == 17);
        check("image_wc0", obs_count(0), 14);
        check("image_wc1", obs_count(1), 4);
        check("image_done", o_done, 1);

        // Reload the same image with random valid gaps; start pulses inside LOAD are ignored.
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++) begin
            for (int g = 0; g < 16 && $urandom_range(0, 1) == 1; g++)
                step(0, 1'($urandom_range(0, 1)), 0, 2'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            step(0, 0, 1, img_sel[i], img_dat[i], i == 17);
        end
        check("gap_wc0", obs_count(0), 14);
        check("gap_wc1", obs_count(1), 4);
        check("gap_stall", o_stall, 0);

        // Depth overflow on the 4-word, 3-target instance.
        select(1, 3, 4);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, $urandom, 0);
        check("depth_err", o_err, 1);
        check("depth_stall", o_stall, 1);
        check("depth_wc0", obs_count(0), 4);

        // Out-of-range target, then restart from ERROR and load target 2.
        step(0, 1, 0, 0, 0, 0);
        check_counts();
        step(0, 0, 1, 3, $urandom, 1);
        check("badsel_err", o_err, 1);
        step(0, 1, 0, 0, 0, 0);
        check("restart_err", o_err, 0);
        check("restart_wc0", obs_count(0), 0);
        step(0, 0, 1, 2, $urandom, 0);
        step(0, 0, 1, 2, $urandom, 1);
        check("tgt2_done", o_done, 1);
        check_counts();

        // Reset in the middle of a session drops the pending write; reload starts at address 0.
        select(0, 2, 1024);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, img_dat[4+i], 0);
        step(1, 0, 1, 0, img_dat[7], 0);
        check("midrst_enb", o_enb, 0);
        check("midrst_wc0", obs_count(0), 0);
        check("midrst_ready", o_ready, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, img_dat[8], 0);
        check("reload_addr", o_addr, 0);
        check("reload_enb", o_enb, 3'b001);

`ifdef MEM_LOADER_CHECKSUM_EN
        // Matching and mismatching image checksums.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        sum_bias = 0;
        for (int i = 1; i <= 3; i++) step(0, 0, 1, 0, DW'(i), i == 3);
        check("sum_ok_done", o_done, 1);
        check("sum_ok_value", o_sum, 6);
        step(0, 1, 0, 0, 0, 0);
        sum_bias = 1;
        for (int i = 1; i <= 3; i++) step(0, 0, 1, 0, DW'(i), i == 3);
        check("sum_bad_err", o_err, 1);
        check("sum_bad_wc0", obs_count(0), 3);
        sum_bias = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
